// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with an in-order prefetch FIFO.
//
// Owns the fetch PC and issues word reads over a request/response handshake.
// Returned words are buffered with their PCs and presented one per cycle
// through the IF/ID register. A redirect clears the buffer and discards any
// responses still in flight.
//
// Optional feature: define FETCH_PERF_EN to add the perf_* counter ports.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   imem_req/imem_addr      fetch request and its word address
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid/imem_rdata  in-order response word
//   pc_wr_pending           suppress new requests
//   redirect/redirect_pc    one-cycle PC overwrite
//   stall_d/flush_d         hold / invalidate the IF/ID register
//   instr_d/pc_d/valid_d    IF/ID register outputs
//   perf_fetched/dropped/starve  (FETCH_PERF_EN only) wrapping event counters
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_wr_pending,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_starve
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;  // counts 0..DEPTH
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

  // State
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic          r_valid_d;
  logic [31:0]   r_instr_d;
  logic [31:0]   r_pc_d;

  // Next-state and control
  logic [CW:0]   w_sum;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_discard;
  logic          w_pop;
  logic [31:0]   w_resp_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [CW-1:0] w_occ_nxt;
  logic [CW-1:0] w_outst_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [AW-1:0] w_wptr_nxt;
  logic [AW-1:0] w_rptr_nxt;

  assign w_sum     = {1'b0, r_occ} + {1'b0, r_outst};
  assign w_req     = !reset && !redirect && !pc_wr_pending && (w_sum < LP_DEPTH);
  assign w_accept  = w_req && imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp    = imem_rvalid && (r_outst != '0);
  assign w_push    = w_resp && !redirect && (r_drop == '0);
  assign w_discard = w_resp && (redirect || (r_drop != '0));
  assign w_pop     = !redirect && !flush_d && !stall_d && (r_occ != '0);

  // A push only happens with drop==0, so every outstanding request is live and
  // they are consecutive words ending just below fetch_pc: the oldest one sits
  // outst words back.
  assign w_resp_pc = r_fetch_pc - {{(30 - CW){1'b0}}, r_outst, 2'b00};

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign valid_d   = r_valid_d;

  always_comb begin
    w_fetch_pc_nxt = w_accept ? r_fetch_pc + 32'd4 : r_fetch_pc;
    w_outst_nxt    = r_outst + CW'(w_accept) - CW'(w_resp);
    w_drop_nxt     = r_drop - CW'(w_discard);
    w_occ_nxt      = r_occ + CW'(w_push) - CW'(w_pop);
    w_wptr_nxt     = r_wptr + AW'(w_push);
    w_rptr_nxt     = r_rptr + AW'(w_pop);
    if (redirect) begin
      // No issue this cycle; every response still owed belongs to the old path.
      w_fetch_pc_nxt = redirect_pc;
      w_drop_nxt     = r_outst - CW'(w_resp);
      w_occ_nxt      = '0;
      w_wptr_nxt     = '0;
      w_rptr_nxt     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_occ      <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_occ      <= w_occ_nxt;
      r_outst    <= w_outst_nxt;
      r_drop     <= w_drop_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]    <= w_resp_pc;
      r_fifo_instr[r_wptr] <= imem_rdata;
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'h0;
    end else if (redirect || flush_d) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP_INSTR;
    end else if (stall_d) begin
      r_valid_d <= r_valid_d;
    end else if (r_occ != '0) begin
      r_valid_d <= 1'b1;
      r_instr_d <= r_fifo_instr[r_rptr];
      r_pc_d    <= r_fifo_pc[r_rptr];
    end else begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  logic w_starve;
  assign w_starve = !redirect && !flush_d && !stall_d && (r_occ == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
      perf_starve  <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(w_push);
      perf_dropped <= perf_dropped + 32'(w_discard);
      perf_starve  <= perf_starve + 32'(w_starve);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_wr_pending;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_starve;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_wr_pending(pc_wr_pending), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_starve(perf_starve)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit drop; } os_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // Reference model: explicit queues of buffered words and in-flight PCs.
  ent_t  m_fifo[$];
  os_t   m_os[$];
  mreq_t mem_q[$];
  logic [31:0] m_fetch_pc, m_instr, m_pc;
  bit    m_valid;
  logic [31:0] m_fetched, m_dropped, m_starve;

  int lat = 1;
  int cyc = 0;
  bit spurious = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'hE280_0001 + (a >> 2);
  endfunction

  function automatic bit m_req();
    return !redirect && !pc_wr_pending && ((m_fifo.size() + m_os.size()) < DEPTH);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_os.delete();
    mem_q.delete();
    m_fetch_pc = RST_PC;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc = 32'h0;
    m_fetched = 0;
    m_dropped = 0;
    m_starve = 0;
  endtask

  task automatic model_step();
    bit acc, resp;
    os_t o;
    ent_t e;
    mreq_t r;
    acc  = m_req() && imem_ready;
    resp = imem_rvalid && (m_os.size() > 0);
    if (acc) begin
      r.addr = m_fetch_pc;
      r.due = cyc + lat;
      mem_q.push_back(r);
    end
    // IF/ID sees the buffer as it was before this edge.
    if (redirect || flush_d) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (stall_d) begin
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      m_valid = 1'b1;
      m_instr = e.instr;
      m_pc = e.pc;
    end else begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_starve++;
    end
    if (redirect) begin
      if (resp) begin
        void'(m_os.pop_front());
        m_dropped++;
      end
      foreach (m_os[i]) m_os[i].drop = 1'b1;
      m_fifo.delete();
      m_fetch_pc = redirect_pc;
    end else begin
      if (resp) begin
        o = m_os.pop_front();
        if (o.drop) m_dropped++;
        else begin
          e.pc = o.pc;
          e.instr = imem_rdata;
          m_fifo.push_back(e);
          m_fetched++;
        end
      end
      if (acc) begin
        o.pc = m_fetch_pc;
        o.drop = 1'b0;
        m_os.push_back(o);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  // One clock: caller sets inputs at the negedge; returns at the next negedge.
  task automatic cycle();
    if (spurious) begin
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    chk("imem_addr", imem_addr, m_fetch_pc);
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pc);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
    chk("perf_starve", perf_starve, m_starve);
`endif
  endtask

  task automatic clear_inputs();
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    pc_wr_pending = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    spurious = 1'b0;
  endtask

  task automatic do_reset();
    imem_rvalid = 1'b0;
    spurious = 1'b0;
    reset = 1'b1;
    #1;
    chk("req_in_reset", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_valid_d", {31'b0, valid_d}, 32'h0);
    chk("rst_instr_d", instr_d, NOP);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming, L=1.
    lat = 1;
    imem_ready = 1'b1;
    cycle();
    chk("addr_after_first", imem_addr, 32'h4);
    cycle();
    cycle();
    chk("first_valid", {31'b0, valid_d}, 32'h1);
    chk("first_pc", pc_d, 32'h0);
    chk("first_instr", instr_d, 32'hE280_0001);
    cycle();
    chk("second_pc", pc_d, 32'h4);

    // Stall with the buffer filling up.
    stall_d = 1'b1;
    repeat (6) cycle();
    chk("stall_hold_instr", instr_d, 32'hE280_0002);
    chk("stall_hold_pc", pc_d, 32'h4);
    #1;
    chk("stall_full_req", {31'b0, imem_req}, 32'h0);
    stall_d = 1'b0;
    cycle();
    chk("stall_rel_pc8", pc_d, 32'h8);
    cycle();
    chk("stall_rel_pc12", pc_d, 32'hC);

    // PC write pending: no issue, buffer drains.
    pc_wr_pending = 1'b1;
    repeat (7) cycle();
    chk("pcwp_req", {31'b0, imem_req}, 32'h0);
    chk("pcwp_drained", {31'b0, valid_d}, 32'h0);

    // Flush and stall together.
    pc_wr_pending = 1'b0;
    stall_d = 1'b1;
    repeat (3) cycle();
    pc_wr_pending = 1'b1;
    flush_d = 1'b1;
    cycle();
    chk("flush_valid", {31'b0, valid_d}, 32'h0);
    chk("flush_instr", instr_d, NOP);
    flush_d = 1'b0;
    stall_d = 1'b0;
    cycle();
    chk("after_flush_valid", {31'b0, valid_d}, 32'h1);
    pc_wr_pending = 1'b0;

    // Redirect with L=3 and requests in flight.
    lat = 3;
    repeat (6) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (valid_d) found = 1'b1;
    end
    chk("redir_seen", {31'b0, found}, 32'h1);
    chk("redir_pc", pc_d, 32'h100);
    chk("redir_instr", instr_d, 32'hE280_0041);

    // Fetch PC wrap.
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    chk("wrap_addr", imem_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (valid_d) found = 1'b1;
    end
    chk("wrap_pc", pc_d, 32'hFFFF_FFFC);

    // Spurious response with nothing outstanding.
    pc_wr_pending = 1'b1;
    do_reset();
    spurious = 1'b1;
    cycle();
    spurious = 1'b0;
    cycle();
    chk("spur_valid", {31'b0, valid_d}, 32'h0);
`ifdef FETCH_PERF_EN
    chk("spur_fetched", perf_fetched, 32'h0);
    chk("spur_dropped", perf_dropped, 32'h0);
`endif
    pc_wr_pending = 1'b0;
    cycle();
    chk("spur_addr", imem_addr, 32'h4);

    // Randomized traffic.
    for (int ph = 0; ph < 8; ph++) begin
      lat = int'($urandom_range(1, 4));
      if (ph == 4) do_reset();
      for (int c = 0; c < 400; c++) begin
        imem_ready = ($urandom % 4) != 0;
        stall_d = ($urandom % 6) == 0;
        flush_d = ($urandom % 15) == 0;
        pc_wr_pending = ($urandom % 8) == 0;
        redirect = ($urandom % 25) == 0;
        redirect_pc = (($urandom % 4) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
        cycle();
      end
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
